// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: state encoding and field limits shared by the stopwatch and countdown timer
package stopwatch_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PAUSE, S_RUN, S_DONE} state_e;
  localparam logic [9:0] MAX_MS  = 10'd999;
  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: one-cycle tick every CLK_PER_MS enabled cycles
module ms_tick_gen #(
  parameter int CLK_PER_MS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = CLK_PER_MS > 1 ? $clog2(CLK_PER_MS) : 1;
  localparam logic [W-1:0] TC = W'(CLK_PER_MS - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == TC;
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/digital_countdown_timer.sv
// digital_countdown_timer: loadable min:sec:ms countdown with start/stop and expiry flags
import stopwatch_pkg::*;
module digital_countdown_timer #(
  parameter int CLK_PER_MS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic [9:0] load_ms,
  input  logic       start,
  input  logic       stop,
  output logic [9:0] milisec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       running,
  output logic       expired,
  output logic       done
);
  state_e state_q, state_d;
  logic [9:0] ms_q, ms_d, lms;
  logic [5:0] sec_q, sec_d, min_q, min_d, lsec, lmin;
  logic running_q, expired_q, expired_d, done_q, done_d, tick;
  assign lms  = load_ms > MAX_MS ? MAX_MS : load_ms;
  assign lsec = load_sec > MAX_SEC ? MAX_SEC : load_sec;
  assign lmin = load_min > MAX_MIN ? MAX_MIN : load_min;
  // prescaler restarts on RUN entry and whenever RUN is left
  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == S_RUN),
    .clr  (state_q != S_RUN || state_d != S_RUN),
    .tick (tick)
  );
  always_comb begin
    state_d   = state_q;
    ms_d      = ms_q;
    sec_d     = sec_q;
    min_d     = min_q;
    expired_d = expired_q;
    done_d    = 1'b0;
    if (clear) begin
      state_d   = S_IDLE;
      ms_d      = '0;
      sec_d     = '0;
      min_d     = '0;
      expired_d = 1'b0;
    end else if (load && state_q != S_RUN) begin
      ms_d      = lms;
      sec_d     = lsec;
      min_d     = lmin;
      expired_d = 1'b0;
      state_d   = (lms != 0 || lsec != 0 || lmin != 0) ? S_PAUSE : S_IDLE;
    end else if (state_q == S_PAUSE) begin
      state_d = (start && !stop) ? S_RUN : S_PAUSE;
    end else if (state_q == S_RUN) begin
      if (stop || !start) state_d = S_PAUSE;
      else if (tick) begin
        // RUN always holds a non-zero value, so the borrow chain cannot underflow
        ms_d  = ms_q != 0 ? ms_q - 10'd1 : MAX_MS;
        sec_d = ms_q != 0 ? sec_q : sec_q != 0 ? sec_q - 6'd1 : MAX_SEC;
        min_d = (ms_q == 0 && sec_q == 0) ? min_q - 6'd1 : min_q;
        if (min_q == 0 && sec_q == 0 && ms_q == 10'd1) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          expired_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= S_IDLE;
      ms_q      <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_q      <= ms_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      running_q <= state_d == S_RUN;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  assign milisec = ms_q;
  assign sec     = sec_q;
  assign min     = min_q;
  assign running = running_q;
  assign expired = expired_q;
  assign done    = done_q;
endmodule
